// File: rtl/axis_stream_checker.sv
// AXI-Stream checker for the incrementing-counter test pattern: verifies sequence
// continuity and tlast-delimited packet length, keeps saturating statistics.
module axis_stream_checker #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    input  logic              cfg_enable,
    input  logic              cfg_clear,
    input  logic [CNT_W-1:0]  cfg_packet_size,
    input  logic [7:0]        cfg_ready_mask,
    output logic [CNT_W-1:0]  stat_beats,
    output logic [CNT_W-1:0]  stat_packets,
    output logic [CNT_W-1:0]  stat_seq_err,
    output logic [CNT_W-1:0]  stat_len_err,
    output logic [DATA_W-1:0] stat_last_data,
    output logic              stat_err_sticky,
    output logic [1:0]        stat_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [2:0]        phase;
    logic [2:0]        phase_nxt;
    logic              en_d;
    logic [DATA_W-1:0] expected;
    logic [CNT_W-1:0]  beat_in_pkt;
    logic              accept;
    logic              ready_nxt;
    logic              seq_err;
    logic              len_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        accept    = s_axis_tvalid & s_axis_tready;
        phase_nxt = cfg_enable ? phase + 3'd1 : 3'd0;
        // en_d holds ready low for the first enabled cycle
        ready_nxt = cfg_enable & ((state != IDLE) | en_d) & cfg_ready_mask[phase_nxt];
        seq_err   = accept & (state == RUN) & (s_axis_tdata != expected);
        // one extra bit so a saturated beat count cannot wrap into a false match
        len_err   = accept & s_axis_tlast & (cfg_packet_size != '0) &
                    (({1'b0, beat_in_pkt} + 1'b1) != {1'b0, cfg_packet_size});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            phase         <= 3'd0;
            en_d          <= 1'b0;
            s_axis_tready <= 1'b0;
            expected      <= '0;
            beat_in_pkt   <= '0;
        end else begin
            phase         <= phase_nxt;
            en_d          <= cfg_enable;
            s_axis_tready <= ready_nxt;
            if (accept)
                expected <= s_axis_tdata + 1'b1;
            if (!cfg_enable) begin
                state       <= IDLE;
                beat_in_pkt <= '0;
            end else begin
                case (state)
                    IDLE:    state <= SYNC;
                    SYNC:    if (accept) state <= RUN;
                    RUN:     state <= RUN;
                    default: state <= IDLE;
                endcase
                if (accept)
                    beat_in_pkt <= s_axis_tlast ? '0 : sat_inc(beat_in_pkt);
            end
        end
    end

    // clear takes priority over a coincident accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_beats      <= '0;
            stat_packets    <= '0;
            stat_seq_err    <= '0;
            stat_len_err    <= '0;
            stat_last_data  <= '0;
            stat_err_sticky <= 1'b0;
        end else if (cfg_clear) begin
            stat_beats      <= '0;
            stat_packets    <= '0;
            stat_seq_err    <= '0;
            stat_len_err    <= '0;
            stat_last_data  <= '0;
            stat_err_sticky <= 1'b0;
        end else if (accept) begin
            stat_beats     <= sat_inc(stat_beats);
            stat_last_data <= s_axis_tdata;
            if (s_axis_tlast)
                stat_packets <= sat_inc(stat_packets);
            if (seq_err)
                stat_seq_err <= sat_inc(stat_seq_err);
            if (len_err)
                stat_len_err <= sat_inc(stat_len_err);
            if (seq_err | len_err)
                stat_err_sticky <= 1'b1;
        end
    end

    assign stat_state = state;

endmodule

// File: doc/axis_stream_checker.md
Name: axis_stream_checker

Overview:
AXI-Stream slave that consumes the 64-bit incrementing-counter stream produced by the PL test-pattern source and verifies it beat by beat. It checks sequence continuity and packet length delimited by tlast, and accumulates saturating statistics. It applies a programmable back-pressure pattern on tready. Configuration and statistics ports connect to the sys-bus register block; all logic is in one clock domain.

Parameters:
DATA_W, 64, stream data width; compared value and expected counter width
CNT_W, 32, width of every statistics counter and of cfg_packet_size

Ports:
clk  in  1  stream and logic clock
rst  in  1  asynchronous active-high reset
s_axis_tdata  in  DATA_W  stream data
s_axis_tvalid  in  1  source data valid
s_axis_tlast  in  1  last beat of packet
s_axis_tready  out  1  checker ready (registered)
cfg_enable  in  1  level; 0 forces IDLE, tready low
cfg_clear  in  1  single-cycle pulse; zeroes all statistics and sticky flag
cfg_packet_size  in  CNT_W  expected beats per packet; 0 disables length check
cfg_ready_mask  in  8  tready duty pattern; bit i gates ready in phase i
stat_beats  out  CNT_W  accepted beats
stat_packets  out  CNT_W  accepted tlast beats
stat_seq_err  out  CNT_W  data-continuity errors
stat_len_err  out  CNT_W  packet-length errors
stat_last_data  out  DATA_W  data of most recent accepted beat
stat_err_sticky  out  1  set on any error, cleared by cfg_clear/rst
stat_state  out  2  FSM state: 0 IDLE, 1 SYNC, 2 RUN

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM IDLE; phase=0; expected=0; beat_in_pkt=0.
- Accept = s_axis_tvalid & s_axis_tready in the same cycle. Only accepted beats update state or statistics.
- Phase: 3-bit counter, +1 every clk while cfg_enable=1; held at 0 while disabled; wraps 7->0.
- s_axis_tready registered: next value = cfg_enable & (state!=IDLE or cfg_enable was 1 last cycle) & cfg_ready_mask[next phase]. Effect: ready first rises 1 cycle after cfg_enable rises. Mask 8'hFF gives continuous ready; 8'h00 gives permanent stall.
- FSM:
  - IDLE: cfg_enable=1 -> SYNC.
  - SYNC: first accepted beat -> expected=tdata+1, no sequence check; -> RUN.
  - RUN: each accepted beat: tdata!=expected -> stat_seq_err+1 and sticky set. In both cases expected=tdata+1 (resync, no stall).
  - Any state: cfg_enable=0 -> IDLE next cycle. beat_in_pkt=0; statistics retained.
- Expected wraps modulo 2^DATA_W: all-ones followed by 0 is valid.
- Length check: beat_in_pkt counts accepted beats within the current packet.
  - On an accepted tlast beat: if cfg_packet_size!=0 and beat_in_pkt+1 != cfg_packet_size -> stat_len_err+1 and sticky set.
  - Also on an accepted tlast beat: stat_packets+1 and beat_in_pkt=0.
  - beat_in_pkt saturates at all-ones.
- stat_beats +1 per accepted beat. stat_last_data = tdata of the accepted beat.
- All statistics update on the clock edge following acceptance, i.e. 1-cycle latency. Every counter saturates at all-ones, never wraps.
- cfg_clear: synchronous. Zeroes stat_* counters, stat_last_data and sticky. If it coincides with an accepted beat, clear wins and that beat is not counted, but FSM/expected/beat_in_pkt still advance.
- Sequence error and length error on the same beat: both counters increment.
- cfg_packet_size changes mid-packet: the new value applies at the next tlast comparison.
- rst asserted mid-packet: immediate return to reset values; tready drops asynchronously.

Test Plan:
- Enable, mask FF, size 4: 16 beats data 0..15, tlast every 4th -> beats=16, packets=4, seq_err=0, len_err=0, last_data=15, tready high from cycle 2.
- Same stream with data 7 replaced by 100 -> seq_err=2 (at 100 and at 8), sticky=1; following beats error-free.
- Size 4, tlast on beats 3 and 8 of 8 -> packets=2, len_err=2; size 0 with same stream -> len_err=0.
- Mask 8'h55, source tvalid held high -> tready toggles every cycle; 8 beats take 16 cycles; counts exact, no duplicated or dropped beats.
- Data 64'hFFFF_FFFF_FFFF_FFFE..+3 across wrap -> seq_err=0. Force stat_beats to 2^32-1 (preload via long run or force) then one more beat -> stays 32'hFFFFFFFF.
- cfg_clear pulsed on an accepted beat -> all stats 0 next cycle, that beat uncounted. rst mid-packet -> all outputs 0 and state IDLE; re-enable -> SYNC, first beat not checked.
